if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and the instruction memory, and drives the fetch side of the IF/ID pipeline register.
- Produces the current PC, PC+4 and the fetched instruction word every cycle.
- Obeys stall, clock-enable and branch/jump redirects from the ID stage and hazard unit.
- Detects HALT, freezes fetch, and accepts program loading from the debug unit.

Parameters:
- MEM_DEPTH, 256, number of 32-bit instruction words.
- ADDR_W, 8, word-address width; MEM_DEPTH = 2**ADDR_W.
- HALT_OPCODE, 6'b111111, opcode field value (bits 31:26) that stops fetch.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- clk_en  input  1  pipeline step enable from the debug unit; 0 holds PC and counters.
- stall  input  1  hazard-unit stall; 1 holds PC.
- pc_src  input  1  branch taken, resolved in ID.
- branch_target  input  32  branch destination byte address.
- jump  input  1  jump taken, resolved in ID.
- jump_target  input  32  jump destination byte address.
- load_en  input  1  debug program-load write strobe.
- load_addr  input  ADDR_W  word address to write.
- load_data  input  32  instruction word to write.
- if_pc  output  32  current PC.
- if_pc_plus_4  output  32  if_pc + 4, modulo 2^32.
- if_instruction  output  32  mem[if_pc[ADDR_W+1:2]], combinational read.
- halted  output  1  sticky; fetch has stopped on HALT.
- fetch_count  output  32  number of PC advances since reset.

Behaviour:
- Reset (asynchronous): if_pc=0, halted=0, fetch_count=0. if_pc_plus_4=4 and if_instruction=mem[0] follow combinationally.
- Memory contents are not cleared by reset.
- Memory read is combinational from if_pc bits [ADDR_W+1:2]; upper PC bits are ignored, so addresses wrap modulo MEM_DEPTH words.
- Memory write is synchronous: on a rising edge with load_en=1, mem[load_addr] <= load_data, independent of clk_en.
- A write to the current word address becomes visible on if_instruction the cycle after the edge.
- PC update priority per rising edge, highest first:
  1. load_en=1: PC held; halted and fetch_count unchanged.
  2. clk_en=0: PC held.
  3. halted=1: PC held.
  4. stall=1: PC held. A redirect presented during a stall is ignored; ID re-presents it after the stall.
  5. pc_src=1: PC <= {branch_target[31:2],2'b00}.
  6. jump=1: PC <= {jump_target[31:2],2'b00}. If pc_src and jump are both 1, the branch wins.
  7. Otherwise PC <= if_pc + 4; wraps 32'hFFFFFFFC -> 0.
- fetch_count increments by 1, wrapping, on every edge where cases 5-7 apply; otherwise it holds.
- Halt detection: on an edge where case 7 applies and if_instruction[31:26]==HALT_OPCODE:
  - PC is NOT advanced; halted <= 1; fetch_count does not increment.
  - if_instruction keeps presenting the HALT word, so IF/ID can pass it down the pipe.
- A HALT word fetched in a cycle with pc_src or jump is on the wrong path: the redirect is taken and halted stays 0.
- A HALT word fetched during stall=1 or clk_en=0 does not set halted until a cycle where case 7 applies.
- halted clears only on reset.
- Targets with nonzero low 2 bits are force-aligned as above; no exception is raised.
- Outputs if_pc, if_pc_plus_4 and if_instruction are never registered twice: IF/ID latency is the only fetch-to-ID delay.

Test Plan:
- Reset, then load mem[0..3]=ADDI words via load_en with clk_en=0, then clk_en=1 for 3 edges -> if_pc 0,4,8,12; if_instruction tracks the loaded words; fetch_count=3.
- At if_pc=8 assert stall for 2 edges with pc_src=1, branch_target=0x40 -> PC stays 8 and fetch_count is unchanged. Deassert stall with pc_src still 1 -> PC=0x40.
- pc_src=1 and jump=1 in the same cycle, branch_target=0x20, jump_target=0x80 -> PC=0x20. Next, jump only with jump_target=0x83 -> PC=0x80.
- mem[5]=HALT word, run from 0 -> PC reaches 0x14, halted=1 on the next edge, PC stays 0x14 indefinitely, fetch_count=5. Assert reset mid-halt -> PC=0, halted=0 asynchronously.
- HALT at 0x10 presented while pc_src=1, branch_target=0x0 -> PC=0, halted stays 0.
- Load 0xDEADBEEF to the current word address while clk_en=0 -> if_instruction shows 0xDEADBEEF from the following cycle; PC unchanged.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage control and result bundle shared by the IF stage and the units that steer it
// (ID redirects, hazard stall, debug step/load).
interface if_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              clk_en;
   logic              stall;
   logic              pc_src;
   logic [31:0]       branch_target;
   logic              jump;
   logic [31:0]       jump_target;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic [31:0]       if_pc;
   logic [31:0]       if_pc_plus_4;
   logic [31:0]       if_instruction;
   logic              halted;
   logic [31:0]       fetch_count;

   modport master (
      output clk_en, stall, pc_src, branch_target, jump, jump_target,
             load_en, load_addr, load_data,
      input  if_pc, if_pc_plus_4, if_instruction, halted, fetch_count
   );

   modport slave (
      input  clk_en, stall, pc_src, branch_target, jump, jump_target,
             load_en, load_addr, load_data,
      output if_pc, if_pc_plus_4, if_instruction, halted, fetch_count
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: program counter, instruction memory with debug load port,
// redirect/stall handling and sticky HALT detection.
module if_fetch_unit #(
   parameter int         MEM_DEPTH   = 256,
   parameter int         ADDR_W      = 8,
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input logic           clk,
   input logic           reset,
   if_fetch_unit_if.slave bus
);

   typedef enum logic {
      FETCHING,
      HALTED
   } fetch_state_t;

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [31:0]       pc;
   logic [31:0]       pc_next;
   logic [31:0]       count;
   logic [31:0]       count_next;
   logic [31:0]       mem [MEM_DEPTH];
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       instruction;
   logic              can_step;
   logic              unused_target_low_bits;

   // Upper PC bits are ignored, so fetch addresses wrap around the memory.
   assign word_addr   = pc[ADDR_W+1:2];
   assign instruction = mem[word_addr];

   assign unused_target_low_bits = ^{bus.branch_target[1:0], bus.jump_target[1:0]};

   // Program loading is deliberately not gated by clk_en so the debugger can load while paused.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         mem[bus.load_addr] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCHING;
         pc    <= 32'd0;
         count <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
      end
   end

   // A HALT word only stops fetch on a plain sequential step; redirects mean it was on a wrong path.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      count_next = count;
      can_step   = !bus.load_en && bus.clk_en && (state == FETCHING) && !bus.stall;
      if (can_step) begin
         if (bus.pc_src) begin
            pc_next    = {bus.branch_target[31:2], 2'b00};
            count_next = count + 32'd1;
         end else if (bus.jump) begin
            pc_next    = {bus.jump_target[31:2], 2'b00};
            count_next = count + 32'd1;
         end else if (instruction[31:26] == HALT_OPCODE) begin
            state_next = HALTED;
         end else begin
            pc_next    = pc + 32'd4;
            count_next = count + 32'd1;
         end
      end
   end

   assign bus.if_pc          = pc;
   assign bus.if_pc_plus_4   = pc + 32'd4;
   assign bus.if_instruction = instruction;
   assign bus.halted         = (state == HALTED);
   assign bus.fetch_count    = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: table of single-edge vectors plus hand-written
// sequences for halt, asynchronous reset, debug load and PC wrap.
module tb_if_fetch_unit;

   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   logic clk = 1'b0;
   logic reset;

   if_fetch_unit_if #(.ADDR_W(8)) bus ();

   if_fetch_unit #(
      .MEM_DEPTH  (256),
      .ADDR_W     (8),
      .HALT_OPCODE(6'b111111)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        load_en;
      logic [7:0]  load_addr;
      logic [31:0] load_data;
      logic        clk_en;
      logic        stall;
      logic        pc_src;
      logic [31:0] branch_target;
      logic        jump;
      logic [31:0] jump_target;
      logic [31:0] exp_pc;
      logic        exp_halted;
      logic [31:0] exp_count;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] mem_model [256];
   int          vec_count  = 0;
   int          fail_count = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkState(input string name, input logic [31:0] exp_pc, input logic exp_halted,
                             input logic [31:0] exp_count);
      logic [7:0] widx;
      widx = exp_pc[9:2];
      checkOutput({name, " pc"}, bus.if_pc, exp_pc);
      checkOutput({name, " pc+4"}, bus.if_pc_plus_4, exp_pc + 32'd4);
      checkOutput({name, " instr"}, bus.if_instruction, mem_model[widx]);
      checkOutput({name, " halted"}, {31'd0, bus.halted}, {31'd0, exp_halted});
      checkOutput({name, " count"}, bus.fetch_count, exp_count);
   endtask

   task automatic idleInputs();
      bus.clk_en        = 1'b1;
      bus.stall         = 1'b0;
      bus.pc_src        = 1'b0;
      bus.branch_target = 32'd0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'd0;
      bus.load_en       = 1'b0;
      bus.load_addr     = 8'd0;
      bus.load_data     = 32'd0;
   endtask

   task automatic stepEdges(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic loadWord(input logic [7:0] addr, input logic [31:0] data);
      idleInputs();
      bus.clk_en    = 1'b0;
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      stepEdges(1);
      bus.load_en     = 1'b0;
      mem_model[addr] = data;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.load_en       = v.load_en;
      bus.load_addr     = v.load_addr;
      bus.load_data     = v.load_data;
      bus.clk_en        = v.clk_en;
      bus.stall         = v.stall;
      bus.pc_src        = v.pc_src;
      bus.branch_target = v.branch_target;
      bus.jump          = v.jump;
      bus.jump_target   = v.jump_target;
      stepEdges(1);
      if (v.load_en) mem_model[v.load_addr] = v.load_data;
   endtask

   task automatic addVec(input string name, input logic le, input logic [7:0] la, input logic [31:0] ld,
                         input logic ce, input logic st, input logic ps, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic [31:0] ep,
                         input logic eh, input logic [31:0] ec);
      vec_t v;
      v.name = name; v.load_en = le; v.load_addr = la; v.load_data = ld;
      v.clk_en = ce; v.stall = st; v.pc_src = ps; v.branch_target = bt;
      v.jump = jp; v.jump_target = jt;
      v.exp_pc = ep; v.exp_halted = eh; v.exp_count = ec;
      vecs.push_back(v);
   endtask

   initial begin
      idleInputs();
      bus.clk_en = 1'b0;
      reset      = 1'b1;
      #12;
      checkOutput("reset pc", bus.if_pc, 32'd0);
      checkOutput("reset pc+4", bus.if_pc_plus_4, 32'd4);
      checkOutput("reset halted", {31'd0, bus.halted}, 32'd0);
      checkOutput("reset count", bus.fetch_count, 32'd0);
      reset = 1'b0;

      // Every word gets a known non-HALT ADDI so no branch target reads undefined memory.
      for (int i = 0; i < 256; i++) loadWord(8'(i), 32'h2001_0000 | 32'(i));
      loadWord(8'd5, HALT_WORD);
      checkState("after load", 32'd0, 1'b0, 32'd0);

      //     name            le la     ld             ce st ps bt            jp jt            pc            h  cnt
      addVec("seq1",         0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h04,       0, 32'd1);
      addVec("seq2",         0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h08,       0, 32'd2);
      addVec("seq3",         0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h0C,       0, 32'd3);
      addVec("jump back",    0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        1, 32'h08,       32'h08,       0, 32'd4);
      addVec("stall br 1",   0, 8'd0,  32'd0,         1, 1, 1, 32'h40,       0, 32'd0,        32'h08,       0, 32'd4);
      addVec("stall br 2",   0, 8'd0,  32'd0,         1, 1, 1, 32'h40,       0, 32'd0,        32'h08,       0, 32'd4);
      addVec("br after st",  0, 8'd0,  32'd0,         1, 0, 1, 32'h40,       0, 32'd0,        32'h40,       0, 32'd5);
      addVec("br beats jmp", 0, 8'd0,  32'd0,         1, 0, 1, 32'h20,       1, 32'h80,       32'h20,       0, 32'd6);
      addVec("jump align",   0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        1, 32'h83,       32'h80,       0, 32'd7);
      addVec("clk_en off",   0, 8'd0,  32'd0,         0, 0, 0, 32'd0,        0, 32'd0,        32'h80,       0, 32'd7);
      addVec("clk_en off br",0, 8'd0,  32'd0,         0, 0, 1, 32'h10,       0, 32'd0,        32'h80,       0, 32'd7);
      addVec("br align",     0, 8'd0,  32'd0,         1, 0, 1, 32'h13,       0, 32'd0,        32'h10,       0, 32'd8);
      addVec("jump zero",    0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        1, 32'd0,        32'h00,       0, 32'd9);
      addVec("run 4",        0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h04,       0, 32'd10);
      addVec("run 8",        0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h08,       0, 32'd11);
      addVec("run C",        0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h0C,       0, 32'd12);
      addVec("run 10",       0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h10,       0, 32'd13);
      addVec("run 14",       0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h14,       0, 32'd14);
      addVec("halt stalled", 0, 8'd0,  32'd0,         1, 1, 0, 32'd0,        0, 32'd0,        32'h14,       0, 32'd14);
      addVec("halt paused",  0, 8'd0,  32'd0,         0, 0, 0, 32'd0,        0, 32'd0,        32'h14,       0, 32'd14);
      addVec("halt loading", 1, 8'h80, 32'h2001_0080, 1, 0, 0, 32'd0,        0, 32'd0,        32'h14,       0, 32'd14);
      addVec("halt sets",    0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        0, 32'd0,        32'h14,       1, 32'd14);
      addVec("halted br",    0, 8'd0,  32'd0,         1, 0, 1, 32'd0,        0, 32'd0,        32'h14,       1, 32'd14);
      addVec("halted jump",  0, 8'd0,  32'd0,         1, 0, 0, 32'd0,        1, 32'd0,        32'h14,       1, 32'd14);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkState(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_halted, vecs[i].exp_count);
      end

      // Reset while halted, between clock edges.
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkState("async reset", 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idleInputs();

      stepEdges(5);
      checkState("reach halt", 32'h14, 1'b0, 32'd5);
      checkOutput("halt word", bus.if_instruction, HALT_WORD);
      stepEdges(1);
      checkState("halt set", 32'h14, 1'b1, 32'd5);
      stepEdges(3);
      checkState("halt hold", 32'h14, 1'b1, 32'd5);

      // HALT on a wrong path must be squashed by the redirect.
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      loadWord(8'd4, HALT_WORD);
      checkState("halt4 loaded", 32'd0, 1'b0, 32'd0);
      idleInputs();
      stepEdges(4);
      checkState("at halt4", 32'h10, 1'b0, 32'd4);
      bus.pc_src        = 1'b1;
      bus.branch_target = 32'd0;
      stepEdges(1);
      checkState("halt wrong path", 32'd0, 1'b0, 32'd5);

      loadWord(8'd0, 32'hDEAD_BEEF);
      checkState("load current", 32'd0, 1'b0, 32'd5);
      checkOutput("load deadbeef", bus.if_instruction, 32'hDEAD_BEEF);

      idleInputs();
      bus.jump        = 1'b1;
      bus.jump_target = 32'hFFFF_FFFE;
      stepEdges(1);
      checkState("top of space", 32'hFFFF_FFFC, 1'b0, 32'd6);
      checkOutput("pc+4 wrap", bus.if_pc_plus_4, 32'd0);
      idleInputs();
      stepEdges(1);
      checkState("pc wrap", 32'd0, 1'b0, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
      $finish;
   end

endmodule
